// File: rtl/arb_2x1_if.sv
// Stream bundle for the 2:1 arbiter: two ready/valid inputs (A, B), one registered output
// and the source tag of the held output beat.
interface arb_2x1_if #(
    parameter int DATA_W = 1
) ();
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              sel;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, sel
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, sel
    );
endinterface

// File: rtl/arb_2x1.sv
// Two-input round-robin stream arbiter feeding a single output register.
// It keeps a wrapping per-source count of accepted beats.
module arb_2x1 #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    arb_2x1_if.slave         bus,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              sel_reg;
    logic              prio_reg;
    logic [CNT_W-1:0]  cnt_a_reg;
    logic [CNT_W-1:0]  cnt_b_reg;

    logic              load;
    logic              grant_a;
    logic              grant_b;
    logic [DATA_W-1:0] grant_data;

    // The output register can take a new beat when empty or being drained this cycle.
    assign load    = !out_valid_reg || bus.out_ready;
    assign grant_a = bus.a_valid && (!bus.b_valid || prio_reg);
    assign grant_b = bus.b_valid && (!bus.a_valid || !prio_reg);

    assign bus.a_ready = !rst && load && grant_a;
    assign bus.b_ready = !rst && load && grant_b;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_mux
            assign grant_data[gi] = grant_a ? bus.a_data[gi] : bus.b_data[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            sel_reg       <= 1'b0;
            prio_reg      <= 1'b1;
            cnt_a_reg     <= '0;
            cnt_b_reg     <= '0;
        end else begin
            if (load) begin
                if (grant_a || grant_b) begin
                    out_data_reg  <= grant_data;
                    sel_reg       <= grant_a;
                    out_valid_reg <= 1'b1;
                    // Favour the side that lost so both valid gives A, B, A, B...
                    prio_reg      <= !grant_a;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end
            if (bus.a_ready) begin
                cnt_a_reg <= cnt_a_reg + 1'b1;
            end
            if (bus.b_ready) begin
                cnt_b_reg <= cnt_b_reg + 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.sel       = sel_reg;
    assign cnt_a         = cnt_a_reg;
    assign cnt_b         = cnt_b_reg;
endmodule

// File: doc/arb_2x1.md
ARB_2X1 -- requirements
Module: arb_2x1

Interface
REQ-001 The block SHALL have parameter DATA_W, default 1, meaning the payload width of each input stream and the output stream.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of each per-source accept counter.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port a_valid, input, 1: source A has a beat.
REQ-007 Port a_data, input, DATA_W: source A payload.
REQ-008 Port a_ready, output, 1: block accepts the source A beat this cycle.
REQ-009 Port b_valid, input, 1: source B has a beat.
REQ-010 Port b_data, input, DATA_W: source B payload.
REQ-011 Port b_ready, output, 1: block accepts the source B beat this cycle.
REQ-012 Port out_valid, output, 1: output register holds a beat.
REQ-013 Port out_data, output, DATA_W: registered payload.
REQ-014 Port out_ready, input, 1: downstream consumes the beat.
REQ-015 Port sel, output, 1: source of the held beat, with 1 = A and 0 = B, matching the 2:1 mux select convention.
REQ-016 Port cnt_a, output, CNT_W: number of beats accepted from A.
REQ-017 Port cnt_b, output, CNT_W: number of beats accepted from B.

Function
REQ-018 Handshake: a transfer occurs on any cycle where valid and ready are both 1.
- a_ready and b_ready may depend combinationally on a_valid, b_valid, out_valid, out_ready and prio.
- out_valid SHALL NOT depend on out_ready.
REQ-019 The load condition SHALL be load = !out_valid | out_ready, so the block sustains one beat per cycle.
REQ-020 Grant rules; prio is the internal 1-bit priority pointer (1 = A favoured):
- only A valid -> grant A;
- only B valid -> grant B;
- both valid -> grant the side named by prio;
- neither valid -> no grant.
REQ-021 a_ready SHALL equal load & grant_A and b_ready SHALL equal load & grant_B; at most one is 1 in any cycle.
REQ-022 On an accepted beat, the following SHALL happen at the next edge:
- out_data <= granted payload;
- sel <= granted side;
- out_valid <= 1;
- prio <= opposite of the granted side.
REQ-023 When load = 1 and there is no grant, out_valid SHALL go to 0 at the next edge; out_data and sel SHALL hold their last values.
REQ-024 Stall: while out_valid = 1 and out_ready = 0, out_data and sel SHALL remain stable, and a_ready = b_ready = 0.
REQ-025 Latency SHALL be exactly 1 cycle from input acceptance to out_valid.
REQ-026 Input data is sampled only when accepted; a valid beat that is not granted SHALL remain pending and not be dropped.
REQ-027 cnt_a SHALL increment by 1 on each A transfer and cnt_b on each B transfer; both wrap modulo 2^CNT_W (all-ones + 1 -> 0) without a flag.
REQ-028 Fairness: with both sources continuously valid and out_ready = 1, grants SHALL alternate A, B, A, B...
REQ-029 prio SHALL not change on cycles with no transfer.

Reset
REQ-030 While rst = 1 at an edge, the next state SHALL be:
- out_valid = 0, out_data = 0, sel = 0;
- prio = 1;
- cnt_a = 0, cnt_b = 0.
REQ-031 While rst = 1, a_ready and b_ready SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard any held output beat; no partial state survives.
REQ-033 The first arbitration after reset with both sources valid SHALL grant A.

Verification
REQ-034 Reset release with a_valid = b_valid = 1, a_data = 1, b_data = 0, out_ready = 1 -> per-cycle grants A, B, A, B; out_data 1, 0, 1, 0 with sel 1, 0, 1, 0, each one cycle after acceptance.
REQ-035 Only b_valid = 1 for 3 cycles with out_ready = 1 -> 3 B beats out; cnt_b = 3, cnt_a = 0; then both valid -> A granted next (prio = 1).
REQ-036 Output held with out_ready = 0 for 4 cycles while both inputs are valid -> a_ready = b_ready = 0; out_data and sel stable; on out_ready = 1 a new beat loads in the same cycle.
REQ-037 CNT_W = 8, 256 A transfers -> cnt_a returns to 0; 257th transfer -> cnt_a = 1.
REQ-038 rst pulsed while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, sel = 0, counters = 0, prio = 1.
REQ-039 Random valid/ready stimulus for 1000 cycles -> scoreboard confirms no beat is lost or duplicated and per-source order is preserved.
